sdram_arbiter: RTL and testbench

- Shares the single SDRAM controller port between three users: refresh requests, the Z80 memory port (main ramRd/ramWr/ramA) and an auxiliary port (DMA / frame-buffer fetch for the HDMI path).
- Sits between the requesters and the sdram controller.
- Drives the controller's refresh/read/write strobes, portA and portD, and returns portQ data to the granted requester.
- Uses a fixed-latency timing model of the controller, so no controller acknowledge is needed.

---
 rtl/sdram_arb_pkg.sv | 11 +
 rtl/sdram_arb_prio.sv | 30 +++
 rtl/sdram_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and default timing for the SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_RF, OWN_CPU, OWN_AUX} owner_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int unsigned DEFAULT_CMD_CYCLES = 8;
  localparam int unsigned DEFAULT_READ_LAT   = 6;
  localparam int unsigned DEFAULT_MAX_CONSEC = 4;

endpackage

// File: rtl/sdram_arb_prio.sv
// Combinational grant selector: refresh, then CPU, then aux, with aux forced
// ahead of the CPU once the CPU has taken MAX_CONSEC grants while aux waited.
module sdram_arb_prio
  import sdram_arb_pkg::*;
#(
  parameter int unsigned MAX_CONSEC = DEFAULT_MAX_CONSEC,
  parameter int unsigned CW         = $clog2(DEFAULT_MAX_CONSEC + 1)
) (
  input  logic          ready,
  input  logic          rf_pend_nz,
  input  logic          cpu_req,
  input  logic          aux_req,
  input  logic [CW-1:0] consec,
  output owner_t        grant_c
);

  always_comb begin
    grant_c = OWN_NONE;
    if (ready) begin
      if (rf_pend_nz) begin
        grant_c = OWN_RF;
      end else if (aux_req && (!cpu_req || consec == CW'(MAX_CONSEC))) begin
        grant_c = OWN_AUX;
      end else if (cpu_req) begin
        grant_c = OWN_CPU;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between refresh, the Z80 port and an aux
// port, using a fixed-latency model of the controller (no acknowledge needed).
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned AW         = 24,
  parameter int unsigned DW         = 16,
  parameter int unsigned CMD_CYCLES = DEFAULT_CMD_CYCLES,
  parameter int unsigned READ_LAT   = DEFAULT_READ_LAT,
  parameter int unsigned MAX_CONSEC = DEFAULT_MAX_CONSEC
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ready,
  input  logic          rfReq,
  input  logic          cpuReq,
  input  logic          cpuWe,
  input  logic [AW-1:0] cpuA,
  input  logic [DW-1:0] cpuD,
  output logic [DW-1:0] cpuQ,
  output logic          cpuAck,
  input  logic          auxReq,
  input  logic          auxWe,
  input  logic [AW-1:0] auxA,
  input  logic [DW-1:0] auxD,
  output logic [DW-1:0] auxQ,
  output logic          auxAck,
  output logic          sdrRf,
  output logic          sdrRd,
  output logic          sdrWr,
  output logic [AW-1:0] sdrA,
  output logic [DW-1:0] sdrD,
  input  logic [DW-1:0] sdrQ,
  output logic          rfOvf
);

  localparam int unsigned CNTW = (CMD_CYCLES > 1) ? $clog2(CMD_CYCLES) : 1;
  localparam int unsigned CW   = $clog2(MAX_CONSEC + 1);
  localparam logic [CNTW-1:0] CNT_LOAD   = CNTW'(CMD_CYCLES - 1);
  // Busy count seen in the cycle READ_LAT cycles after the strobe cycle (READ_LAT < CMD_CYCLES).
  localparam logic [CNTW-1:0] CNT_SAMPLE = CNTW'(CMD_CYCLES - 1 - READ_LAT);

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d, grant_c;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            is_rd_q, is_rd_d;
  logic [1:0]      rf_pend_q, rf_pend_d;
  logic [CW-1:0]   consec_q, consec_d;
  logic            rf_grant;

  logic          sdr_rf_d, sdr_rd_d, sdr_wr_d, cpu_ack_d, aux_ack_d, rf_ovf_d;
  logic [AW-1:0] sdr_a_d;
  logic [DW-1:0] sdr_d_d, cpu_q_d, aux_q_d;

  // A refresh pulse arriving this cycle counts as pending so it is not overtaken.
  sdram_arb_prio #(.MAX_CONSEC(MAX_CONSEC), .CW(CW)) u_prio (
    .ready      (ready),
    .rf_pend_nz (rf_pend_q != 2'd0 || rfReq),
    .cpu_req    (cpuReq),
    .aux_req    (auxReq),
    .consec     (consec_q),
    .grant_c    (grant_c)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    is_rd_d   = is_rd_q;
    rf_pend_d = rf_pend_q;
    consec_d  = consec_q;
    rf_ovf_d  = rfOvf;
    sdr_rf_d  = 1'b0;
    sdr_rd_d  = 1'b0;
    sdr_wr_d  = 1'b0;
    cpu_ack_d = 1'b0;
    aux_ack_d = 1'b0;
    sdr_a_d   = sdrA;
    sdr_d_d   = sdrD;
    cpu_q_d   = cpuQ;
    aux_q_d   = auxQ;
    rf_grant  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_c != OWN_NONE) begin
          owner_d = grant_c;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
          unique case (grant_c)
            OWN_RF: begin
              rf_grant = 1'b1;
              sdr_rf_d = 1'b1;
              is_rd_d  = 1'b0;
              sdr_a_d  = '0;
              sdr_d_d  = '0;
            end
            OWN_CPU: begin
              sdr_wr_d = cpuWe;
              sdr_rd_d = !cpuWe;
              is_rd_d  = !cpuWe;
              sdr_a_d  = cpuA;
              sdr_d_d  = cpuD;
              if (!auxReq)                          consec_d = '0;
              else if (consec_q != CW'(MAX_CONSEC)) consec_d = consec_q + CW'(1);
            end
            OWN_AUX: begin
              sdr_wr_d = auxWe;
              sdr_rd_d = !auxWe;
              is_rd_d  = !auxWe;
              sdr_a_d  = auxA;
              sdr_d_d  = auxD;
              consec_d = '0;
            end
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (is_rd_q && cnt_q == CNT_SAMPLE) begin
          if (owner_q == OWN_CPU) cpu_q_d = sdrQ;
          if (owner_q == OWN_AUX) aux_q_d = sdrQ;
        end
        if (cnt_q == '0) begin
          state_d   = DONE;
          cpu_ack_d = (owner_q == OWN_CPU);
          aux_ack_d = (owner_q == OWN_AUX);
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = IDLE;
    endcase

    // Pending refresh count; a request that would overflow is dropped and flagged.
    unique case ({rfReq, rf_grant})
      2'b10: begin
        if (rf_pend_q == 2'd3) rf_ovf_d  = 1'b1;
        else                   rf_pend_d = rf_pend_q + 2'd1;
      end
      2'b01:   rf_pend_d = rf_pend_q - 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      cnt_q     <= '0;
      is_rd_q   <= 1'b0;
      rf_pend_q <= '0;
      consec_q  <= '0;
      rfOvf     <= 1'b0;
      sdrRf     <= 1'b0;
      sdrRd     <= 1'b0;
      sdrWr     <= 1'b0;
      cpuAck    <= 1'b0;
      auxAck    <= 1'b0;
      sdrA      <= '0;
      sdrD      <= '0;
      cpuQ      <= '0;
      auxQ      <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      is_rd_q   <= is_rd_d;
      rf_pend_q <= rf_pend_d;
      consec_q  <= consec_d;
      rfOvf     <= rf_ovf_d;
      sdrRf     <= sdr_rf_d;
      sdrRd     <= sdr_rd_d;
      sdrWr     <= sdr_wr_d;
      cpuAck    <= cpu_ack_d;
      auxAck    <= aux_ack_d;
      sdrA      <= sdr_a_d;
      sdrD      <= sdr_d_d;
      cpuQ      <= cpu_q_d;
      auxQ      <= aux_q_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a fixed-latency controller read model.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;
  localparam int RL   = 6;
  localparam int K_RF = 1;
  localparam int K_RD = 2;
  localparam int K_WR = 3;

  logic          clock  = 1'b0;
  logic          reset  = 1'b1;
  logic          ready  = 1'b0;
  logic          rfReq  = 1'b0;
  logic          cpuReq = 1'b0;
  logic          cpuWe  = 1'b0;
  logic [AW-1:0] cpuA   = '0;
  logic [DW-1:0] cpuD   = '0;
  logic          auxReq = 1'b0;
  logic          auxWe  = 1'b0;
  logic [AW-1:0] auxA   = '0;
  logic [DW-1:0] auxD   = '0;
  logic [DW-1:0] sdrQ   = 16'hDEAD;
  logic [DW-1:0] cpuQ, auxQ, sdrD;
  logic [AW-1:0] sdrA;
  logic          cpuAck, auxAck, sdrRf, sdrRd, sdrWr, rfOvf;

  sdram_arbiter #(
    .AW(AW), .DW(DW), .CMD_CYCLES(8), .READ_LAT(6), .MAX_CONSEC(4)
  ) dut (
    .clock(clock), .reset(reset), .ready(ready), .rfReq(rfReq),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ), .cpuAck(cpuAck),
    .auxReq(auxReq), .auxWe(auxWe), .auxA(auxA), .auxD(auxD), .auxQ(auxQ), .auxAck(auxAck),
    .sdrRf(sdrRf), .sdrRd(sdrRd), .sdrWr(sdrWr), .sdrA(sdrA), .sdrD(sdrD), .sdrQ(sdrQ),
    .rfOvf(rfOvf)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    int            cyc;
    int            kind;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } strobe_t;

  strobe_t       slog[$];
  int            cpu_acks = 0;
  int            aux_acks = 0;
  int            rd_strobe_cyc = -100;
  logic [DW-1:0] rd_data = '0;

  // Strobe and ack recorder, sampled mid-cycle.
  always @(negedge clock) begin
    if (sdrRf) slog.push_back({cyc, K_RF, sdrA, sdrD});
    if (sdrWr) slog.push_back({cyc, K_WR, sdrA, sdrD});
    if (sdrRd) begin
      slog.push_back({cyc, K_RD, sdrA, sdrD});
      rd_strobe_cyc = cyc;
    end
    if (cpuAck) cpu_acks++;
    if (auxAck) aux_acks++;
  end

  // Controller model: read data valid only in the cycle READ_LAT after the strobe.
  always @(posedge clock) begin
    #2;
    sdrQ = (cyc == rd_strobe_cyc + RL) ? rd_data : 16'hDEAD;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ack(input bit aux, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((aux ? auxAck : cpuAck) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int t0, at, s0, a0, b0;
    logic [9:0] aux_pat;
    strobe_t e;

    #3 reset = 1'b0;
    ready = 1'b1;
    tick();
    tick();
    check("rst_sdrRd", sdrRd, 0);
    check("rst_cpuAck", cpuAck, 0);
    check("rst_sdrA", sdrA, 0);
    check("rst_rfOvf", rfOvf, 0);
    reset = 1'b1;
    tick();

    // CPU read, uncontended
    rd_data = 16'h5A5A; cpuWe = 1'b0; cpuA = 24'h00ABCD; cpuD = '0; cpuReq = 1'b1;
    t0 = cyc; s0 = slog.size();
    tick();
    check("t1_rd_strobe", sdrRd, 1);
    check("t1_wr_strobe", sdrWr, 0);
    check("t1_sdrA", sdrA, 24'h00ABCD);
    tick();
    check("t1_rd_one_cycle", sdrRd, 0);
    wait_ack(1'b0, 40, at);
    check("t1_ack_cycle", at - t0 + 1, 10);
    check("t1_cpuQ", cpuQ, 16'h5A5A);
    check("t1_sdrA_done", sdrA, 24'h00ABCD);
    cpuReq = 1'b0;
    repeat (3) tick();
    check("t1_n_strobes", slog.size() - s0, 1);

    // CPU write simultaneous with a refresh pulse
    cpuWe = 1'b1; cpuA = 24'h004000; cpuD = 16'h00FF; cpuReq = 1'b1; rfReq = 1'b1;
    t0 = cyc; s0 = slog.size(); a0 = cpu_acks;
    tick();
    rfReq = 1'b0;
    wait_ack(1'b0, 40, at);
    cpuReq = 1'b0;
    check("t2_ack_cycle", at - t0 + 1, 20);
    repeat (12) tick();
    check("t2_n_strobes", slog.size() - s0, 2);
    if (slog.size() - s0 >= 2) begin
      e = slog[s0];
      check("t2_first_kind", e.kind, K_RF);
      check("t2_first_cyc", e.cyc - t0, 1);
      e = slog[s0 + 1];
      check("t2_second_kind", e.kind, K_WR);
      check("t2_second_cyc", e.cyc - t0, 11);
      check("t2_second_a", e.a, 24'h004000);
      check("t2_second_d", e.d, 16'h00FF);
    end
    check("t2_cpu_acks", cpu_acks - a0, 1);

    // Both ports held: CPU x4, aux x1, repeated
    cpuWe = 1'b1; cpuA = 24'h111111; cpuD = 16'h1111; cpuReq = 1'b1;
    auxWe = 1'b1; auxA = 24'h222222; auxD = 16'h2222; auxReq = 1'b1;
    t0 = cyc; s0 = slog.size(); a0 = cpu_acks; b0 = aux_acks;
    aux_pat = 10'b10_0001_0000;
    repeat (99) tick();
    cpuReq = 1'b0; auxReq = 1'b0;
    repeat (15) tick();
    check("t3_n_strobes", slog.size() - s0, 10);
    for (int i = 0; i < 10; i++) begin
      if (s0 + i < slog.size()) begin
        e = slog[s0 + i];
        check($sformatf("t3_owner%0d", i), e.a, aux_pat[i] ? 24'h222222 : 24'h111111);
        check($sformatf("t3_cyc%0d", i), e.cyc - t0, 1 + 10 * i);
      end
    end
    check("t3_cpu_acks", cpu_acks - a0, 8);
    check("t3_aux_acks", aux_acks - b0, 2);

    // Refresh backlog with ready low, then drain
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rfReq = 1'b1;
      tick();
      rfReq = 1'b0;
      tick();
      if (i == 2) begin
        check("t4_pend_after3", dut.rf_pend_q, 3);
        check("t4_ovf_after3", rfOvf, 0);
      end
    end
    check("t4_pend_after4", dut.rf_pend_q, 3);
    check("t4_ovf_after4", rfOvf, 1);
    s0 = slog.size(); t0 = cyc;
    ready = 1'b1;
    repeat (35) tick();
    check("t4_n_strobes", slog.size() - s0, 3);
    for (int i = 0; i < 3; i++) begin
      if (s0 + i < slog.size()) begin
        e = slog[s0 + i];
        check($sformatf("t4_kind%0d", i), e.kind, K_RF);
        check($sformatf("t4_cyc%0d", i), e.cyc - t0, 1 + 10 * i);
      end
    end
    check("t4_ovf_sticky", rfOvf, 1);
    check("t4_pend_drained", dut.rf_pend_q, 0);

    // Reset in the middle of a CPU read
    cpuWe = 1'b0; cpuA = 24'h000777; cpuD = 16'h0AAA; rd_data = 16'h1234; cpuReq = 1'b1;
    a0 = cpu_acks;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("t5_rst_sdrRd", sdrRd, 0);
    check("t5_rst_sdrA", sdrA, 0);
    check("t5_rst_sdrD", sdrD, 0);
    check("t5_rst_cpuQ", cpuQ, 0);
    check("t5_rst_rfOvf", rfOvf, 0);
    check("t5_rst_cpuAck", cpuAck, 0);
    tick();
    tick();
    reset = 1'b1;
    t0 = cyc;
    wait_ack(1'b0, 40, at);
    cpuReq = 1'b0;
    check("t5_ack_cycle", at - t0 + 1, 10);
    check("t5_cpuQ", cpuQ, 16'h1234);
    repeat (3) tick();
    check("t5_cpu_acks", cpu_acks - a0, 1);

    // Aux read with CPU idle
    auxWe = 1'b0; auxA = 24'h123456; rd_data = 16'hBEEF; auxReq = 1'b1;
    t0 = cyc;
    wait_ack(1'b1, 40, at);
    auxReq = 1'b0;
    check("t6_ack_cycle", at - t0 + 1, 10);
    check("t6_auxQ", auxQ, 16'hBEEF);
    check("t6_sdrA", sdrA, 24'h123456);
    check("t6_cpuQ_kept", cpuQ, 16'h1234);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
